serial_addsub: RTL

Parametrised multi-cycle add/subtract unit built around a single DIGIT-bit full-adder/full-subtractor slice that is reused each cycle, with a start/busy/done handshake. It generalises the fixed-width combinational ripple subtractor into a clocked, width- and throughput-configurable datapath element. It serves area-constrained arithmetic paths where latency is acceptable.

---
 rtl/serial_addsub.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Multi-cycle add/subtract unit. One DIGIT-bit adder slice is
//               reused for K = WIDTH/DIGIT cycles, with a start/busy/done
//               handshake. Subtraction is performed as a + ~b + ~bin, so the
//               carry chain holds an inverted borrow in sub mode.
//
// Parameters  : WIDTH  operand/result width (>= 2)
//               DIGIT  bits processed per cycle (must divide WIDTH)
// Macro       : SERIAL_ADDSUB_OVF_EN  - when defined, ovf carries the signed
//               overflow flag; otherwise ovf is tied to 0.
//
// Ports       : clk     rising-edge clock
//               rst_n   asynchronous active-low reset
//               start   request, accepted in IDLE or DONE
//               sub     1 = a - b - bin, 0 = a + b + bin
//               a, b    WIDTH-bit operands
//               bin     borrow-in (sub) / carry-in (add)
//               busy    operation in progress
//               done    one-cycle result-valid pulse
//               result  sum/difference, held between operations
//               brr     borrow-out (sub) / carry-out (add)
//               ovf     signed overflow
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             brr,
    output logic             ovf
);

    localparam int c_steps = WIDTH / DIGIT;
    localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(c_steps - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_chain;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_brr;

    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT:0]     w_sum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_run;
    logic               w_accept;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Single reusable slice: in sub mode b is inverted and the chain holds
    // the complement of the borrow, turning subtraction into an addition.
    assign w_b_dig = r_b[DIGIT-1:0] ^ {DIGIT{r_sub}};
    assign w_sum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_chain};

    // Result digits enter at the MSB end; after the last step the register
    // plus the final digit forms the complete result.
    generate
        if (c_steps > 1) begin : g_acc_shift
            logic [WIDTH-DIGIT-1:0] r_acc;

            assign w_acc_next = {w_sum[DIGIT-1:0], r_acc};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_run) begin
                    r_acc <= w_acc_next[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_acc_single
            assign w_acc_next = w_sum[DIGIT-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_chain  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_brr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_chain <= bin ^ sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_chain <= w_sum[DIGIT];
                    if (r_cnt == c_last_step) begin
                        r_result <= w_acc_next;
                        r_brr    <= w_sum[DIGIT] ^ r_sub;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Operand sign bits are captured at acceptance because the operand
    // registers are consumed by shifting during the run.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (w_run && (r_cnt == c_last_step)) begin
                // add: like signs give unlike result; sub: unlike signs.
                r_ovf <= ((r_a_msb ^ r_b_msb) == r_sub) &&
                         (w_acc_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign brr    = r_brr;

endmodule
`default_nettype wire
